mmio_bridge: RTL

Parametrised memory-mapped I/O bridge between the CPU data port and up to four peripheral devices (timers and similar) at the 0x7F00 I/O window. Decodes the CPU address into a one-hot device select, runs a registered request/ready handshake with the selected device, bounds each access with a timeout, and returns read data or an error flag. Device interrupt lines are registered into the 6-bit `hwint` vector feeding CP0.

---
 rtl/mmio_bridge_pkg.sv | 23 ++
 rtl/mmio_addr_decode.sv | 30 +++
 rtl/mmio_bridge.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mmio_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmio_bridge_pkg
// Description : Shared state encoding and default address map for the MMIO
//               bridge and its address decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package mmio_bridge_pkg;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCESS = 2'd1;
    localparam logic [1:0] c_ST_DONE   = 2'd2;

    localparam logic [31:0] c_DEF_BASE   = 32'h0000_7F00;
    localparam logic [31:0] c_DEF_STRIDE = 32'h0000_0010;
    localparam logic [31:0] c_DEF_SPAN   = 32'h0000_000C;

    // Device interrupts land above the two reserved low bits of hwint.
    localparam int c_IRQ_OFFSET = 2;
    localparam int c_HWINT_W    = 6;

endpackage
`default_nettype wire

// File: rtl/mmio_addr_decode.sv
`default_nettype none
// ============================================================================
// Module      : mmio_addr_decode
// Description : Combinational window decode of a CPU byte address into a
//               one-hot device hit vector plus a miss flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_addr_decode
    import mmio_bridge_pkg::*;
#(
    parameter int          NDEV   = 2,
    parameter logic [31:0] BASE   = c_DEF_BASE,
    parameter logic [31:0] STRIDE = c_DEF_STRIDE,
    parameter logic [31:0] SPAN   = c_DEF_SPAN
) (
    input  logic [31:0]     i_addr,
    output logic [NDEV-1:0] o_hit,
    output logic            o_miss
);

    for (genvar i = 0; i < NDEV; i++) begin : g_dev
        localparam logic [31:0] c_LO = BASE + 32'(i) * STRIDE;
        localparam logic [31:0] c_HI = c_LO + SPAN - 32'd1;
        assign o_hit[i] = (i_addr >= c_LO) && (i_addr <= c_HI);
    end

    assign o_miss = ~|o_hit;

endmodule
`default_nettype wire

// File: rtl/mmio_bridge.sv
`default_nettype none
// ============================================================================
// Module      : mmio_bridge
// Description : CPU-to-peripheral MMIO bridge: address decode, registered
//               request/ready handshake, read-data return, IRQ registering.
//               Define MMIO_BRIDGE_TIMEOUT_EN to bound each device access.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_bridge
    import mmio_bridge_pkg::*;
#(
    parameter int          NDEV    = 2,
    parameter logic [31:0] BASE    = c_DEF_BASE,
    parameter logic [31:0] STRIDE  = c_DEF_STRIDE,
    parameter logic [31:0] SPAN    = c_DEF_SPAN,
    parameter int          TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [31:0]            cpu_addr,
    input  logic [31:0]            cpu_wdata,
    output logic [31:0]            cpu_rdata,
    output logic                   cpu_ready,
    output logic                   cpu_err,
    output logic [NDEV-1:0]        dev_sel,
    output logic                   dev_we,
    output logic [31:0]            dev_addr,
    output logic [31:0]            dev_wdata,
    input  logic [32*NDEV-1:0]     dev_rdata,
    input  logic [NDEV-1:0]        dev_ready,
    input  logic [NDEV-1:0]        dev_irq,
    output logic [c_HWINT_W-1:0]   hwint
);

    logic [1:0]           r_state, w_state_nxt;
    logic [NDEV-1:0]      r_sel, w_sel_nxt;
    logic                 r_we, w_we_nxt;
    logic [31:0]          r_addr, w_addr_nxt;
    logic [31:0]          r_wdata, w_wdata_nxt;
    logic [31:0]          r_rdata, w_rdata_nxt;
    logic                 r_ready, w_ready_nxt;
    logic                 r_err, w_err_nxt;
    logic [c_HWINT_W-1:0] r_hwint, w_hwint_nxt;

    logic [NDEV-1:0]      w_hit;
    logic                 w_miss;
    logic                 w_dev_done;
    logic [31:0]          w_sel_rdata;
    logic                 w_timeout;

    mmio_addr_decode #(
        .NDEV   (NDEV),
        .BASE   (BASE),
        .STRIDE (STRIDE),
        .SPAN   (SPAN)
    ) u_decode (
        .i_addr (cpu_addr),
        .o_hit  (w_hit),
        .o_miss (w_miss)
    );

    // Only the selected device may complete the access or supply data.
    always_comb begin
        w_dev_done  = 1'b0;
        w_sel_rdata = '0;
        for (int i = 0; i < NDEV; i++) begin
            if (r_sel[i]) begin
                w_dev_done  = w_dev_done | dev_ready[i];
                w_sel_rdata = w_sel_rdata | dev_rdata[32*i +: 32];
            end
        end
    end

`ifdef MMIO_BRIDGE_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT + 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_inc;

    assign w_cnt_inc = r_cnt + c_CNT_W'(1);
    assign w_timeout = (w_cnt_inc == c_CNT_W'(TIMEOUT));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (r_state == c_ST_ACCESS) begin
            r_cnt <= w_cnt_inc;
        end else begin
            r_cnt <= '0;
        end
    end
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_unused_timeout = (TIMEOUT != 0);
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_we_nxt    = r_we;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_rdata_nxt = r_rdata;
        w_ready_nxt = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (cpu_req) begin
                    w_addr_nxt  = cpu_addr;
                    w_wdata_nxt = cpu_wdata;
                    if (w_miss) begin
                        w_state_nxt = c_ST_DONE;
                        w_ready_nxt = 1'b1;
                        w_err_nxt   = 1'b1;
                        w_rdata_nxt = '0;
                    end else begin
                        w_state_nxt = c_ST_ACCESS;
                        w_sel_nxt   = w_hit;
                        w_we_nxt    = cpu_we;
                    end
                end
            end
            c_ST_ACCESS: begin
                // Ready takes priority over a timeout landing in the same cycle.
                if (w_dev_done || w_timeout) begin
                    w_state_nxt = c_ST_DONE;
                    w_ready_nxt = 1'b1;
                    w_err_nxt   = ~w_dev_done;
                    w_rdata_nxt = (w_dev_done && !r_we) ? w_sel_rdata : 32'd0;
                    w_sel_nxt   = '0;
                    w_we_nxt    = 1'b0;
                end
            end
            c_ST_DONE: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_sel_nxt   = '0;
                w_we_nxt    = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_hwint_nxt                          = '0;
        w_hwint_nxt[c_IRQ_OFFSET +: NDEV]    = dev_irq;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_ST_IDLE;
            r_sel   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_hwint <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_we    <= w_we_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_rdata <= w_rdata_nxt;
            r_ready <= w_ready_nxt;
            r_err   <= w_err_nxt;
            r_hwint <= w_hwint_nxt;
        end
    end

    assign cpu_rdata = r_rdata;
    assign cpu_ready = r_ready;
    assign cpu_err   = r_err;
    assign dev_sel   = r_sel;
    assign dev_we    = r_we;
    assign dev_addr  = r_addr;
    assign dev_wdata = r_wdata;
    assign hwint     = r_hwint;

endmodule
`default_nettype wire
